debug_inst_scratch_loader: RTL
==============================

Name: debug_inst_scratch_loader

Overview:
Host-side initiator for the debug instruction scratch-pad byte port of the debug instruction RAM. It accepts whole-word write and read requests over a valid/ready channel and serializes each request into eight byte-wide scratch accesses. For reads, it gathers the eight returned bytes into one word and presents it on a response channel. It sits between the debug/test-access controller and the instruction scratch RAM and drives instScratchAddr/WrData/WrEn, consuming instScratchRdData.

Parameters:
INDEX, 8, word-index width (equals DEBUG_INST_RAM_LOG)
BYTE_LOG, 3, log2 of bytes per word (equals DEBUG_INST_RAM_WIDTH_LOG)
WIDTH, 64, word width; must equal 8<<BYTE_LOG

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid_i  in  1  host request valid
req_ready_o  out  1  loader can accept a request
req_write_i  in  1  1 = word write, 0 = word read
req_index_i  in  INDEX  word index in the RAM
req_data_i  in  WIDTH  write data
req_be_i  in  WIDTH/8  byte enables for a write; bit k covers data[8k+7:8k]
rsp_valid_o  out  1  read data valid
rsp_ready_i  in  1  host accepts the read data
rsp_data_o  out  WIDTH  assembled read word
busy_o  out  1  state is not IDLE
scr_addr_o  out  INDEX+BYTE_LOG  scratch address {byte_sel, index}
scr_wr_data_o  out  8  scratch write byte
scr_wr_en_o  out  1  scratch write strobe
scr_rd_data_i  in  8  scratch read byte (combinational from scr_addr_o)

Behaviour:
- Clock and reset: reset is synchronous and active-high; clk is the clock. All state is updated on posedge clk.
- FSM states: IDLE, WRITE, READ, RESP. Reset sets the state to IDLE, byte counter to 0, and the index, data, BE and assembly registers to 0.
- Outputs while reset is asserted: req_ready_o=0, rsp_valid_o=0, busy_o=0, scr_wr_en_o=0, scr_addr_o=0, scr_wr_data_o=0, rsp_data_o=0.
- req_ready_o = (state==IDLE) && !reset.
- Accept: when req_valid_i && req_ready_o are both high at edge T, the loader latches index, data, BE and write flag, and clears cnt.
  - next state is WRITE if req_write_i=1, otherwise READ.
- WRITE (8 cycles, cnt = 0..7):
  - scr_addr_o = {cnt, index}; scr_wr_data_o = data[8*cnt+7 -: 8]; scr_wr_en_o = be[cnt].
  - Masked bytes still take their cycle, with the strobe low.
  - When cnt = 7, next state is IDLE. A write produces no response.
  - Bytes are driven in cycles T+1..T+8; req_ready_o is high again at T+9.
- READ (8 cycles):
  - scr_addr_o = {cnt, index}; scr_wr_en_o = 0.
  - At each edge, rsp_data_o[8*cnt+7 -: 8] <= scr_rd_data_i.
  - When cnt = 7, next state is RESP.
- RESP:
  - rsp_valid_o = 1 and rsp_data_o is held stable.
  - When rsp_ready_i = 1, next state is IDLE. rsp_valid_o first rises at T+9.
- Outside WRITE/READ: scr_addr_o = 0, scr_wr_en_o = 0, scr_wr_data_o = 0.
- Widths:
  - cnt is BYTE_LOG bits wide and wraps 7 -> 0 naturally; the terminal test is cnt == all-ones.
  - The index is never incremented, so there is no index wrap; index 2^INDEX-1 is legal.
- Simultaneous events:
  - A request presented in any non-IDLE state is not accepted (ready=0). The host must hold valid and the request fields stable.
  - A new request presented in the same cycle as a RESP handshake is not accepted until the next cycle (IDLE).
- Reset during WRITE or READ aborts immediately. Bytes already written stay in the RAM, and no response is produced.
- busy_o = (state != IDLE).

Decomposition:
- Shared package (debug_pkg): state enum {IDLE, WRITE, READ, RESP}, and constants DEBUG_INST_RAM_LOG and DEBUG_INST_RAM_WIDTH_LOG, reused from the global header.
- No sub-module; the FSM plus a byte counter is a single module.

Test Plan:
- Write 0x0123456789ABCDEF, be=0xFF, index 5 -> cycles T+1..T+8 show scr_addr_o = {0,5}..{7,5}, wr_data EF,CD,AB,89,67,45,23,01, wr_en=1 throughout; ready returns at T+9.
- Read index 5 after that write, rsp_ready_i=1 -> rsp_valid_o at T+9 with rsp_data_o = 0x0123456789ABCDEF, and exactly one cycle of valid.
- Write 0xFFFF_FFFF_FFFF_FFFF, be=0x0F, to index 5 (word holds 0x0123456789ABCDEF), then read -> 0x01234567FFFFFFFF; wr_en is low in byte cycles 4..7.
- Read with rsp_ready_i held low 5 cycles -> rsp_valid_o and data are stable for 6 cycles; req_ready_o stays 0 until the cycle after the handshake.
- Assert reset at byte 3 of a write of 0xAAAA... to index 255 -> next cycle all outputs are 0 and ready=1 after reset drops; readback of index 255 shows bytes 0..2 = AA and bytes 3..7 unchanged.
- Back-to-back: a write held valid while a read is in RESP -> the write is accepted only in the IDLE cycle after the read handshake, with no byte loss.

Source files
------------

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared debug-block constants and the scratch loader state encoding.
package debug_pkg;

  localparam int DEBUG_INST_RAM_LOG       = 8;
  localparam int DEBUG_INST_RAM_WIDTH_LOG = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/debug_inst_scratch_loader.sv
// rtl/debug_inst_scratch_loader.sv - serializes word reads/writes into byte accesses on the instruction scratch port.
module debug_inst_scratch_loader
  import debug_pkg::*;
#(
  parameter int INDEX    = DEBUG_INST_RAM_LOG,
  parameter int BYTE_LOG = DEBUG_INST_RAM_WIDTH_LOG,
  parameter int WIDTH    = 8 << BYTE_LOG
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [INDEX-1:0]          req_index_i,
  input  logic [WIDTH-1:0]          req_data_i,
  input  logic [WIDTH/8-1:0]        req_be_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [WIDTH-1:0]          rsp_data_o,
  output logic                      busy_o,
  output logic [INDEX+BYTE_LOG-1:0] scr_addr_o,
  output logic [7:0]                scr_wr_data_o,
  output logic                      scr_wr_en_o,
  input  logic [7:0]                scr_rd_data_i
);

  loader_state_t       state_q, state_d;
  logic [BYTE_LOG-1:0] cnt_q, cnt_d;
  logic [INDEX-1:0]    index_q, index_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH/8-1:0]  be_q, be_d;
  logic [WIDTH-1:0]    asm_q, asm_d;
  logic                accept;
  logic                last_byte;

  assign accept    = req_valid_i && (state_q == IDLE) && !reset;
  assign last_byte = (cnt_q == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      index_q <= '0;
      data_q  <= '0;
      be_q    <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      data_q  <= data_d;
      be_q    <= be_d;
      asm_q   <= asm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = req_write_i ? WRITE : READ;
      WRITE: if (last_byte) state_d = IDLE;
      READ:  if (last_byte) state_d = RESP;
      RESP:  if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The byte counter wraps back to zero on the terminal byte, so it is ready for the next request.
  always_comb begin
    cnt_d   = cnt_q;
    index_d = index_q;
    data_d  = data_q;
    be_d    = be_q;
    asm_d   = asm_q;
    if (accept) begin
      cnt_d   = '0;
      index_d = req_index_i;
      data_d  = req_data_i;
      be_d    = req_be_i;
    end else if (state_q == WRITE) begin
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == READ) begin
      cnt_d                = cnt_q + 1'b1;
      asm_d[8*cnt_q +: 8]  = scr_rd_data_i;
    end
  end

  always_comb begin
    req_ready_o   = 1'b0;
    rsp_valid_o   = 1'b0;
    busy_o        = 1'b0;
    scr_addr_o    = '0;
    scr_wr_data_o = '0;
    scr_wr_en_o   = 1'b0;
    rsp_data_o    = reset ? '0 : asm_q;
    if (!reset) begin
      busy_o = (state_q != IDLE);
      case (state_q)
        IDLE:  req_ready_o = 1'b1;
        WRITE: begin
          scr_addr_o    = {cnt_q, index_q};
          scr_wr_data_o = data_q[8*cnt_q +: 8];
          scr_wr_en_o   = be_q[cnt_q];
        end
        READ:  scr_addr_o = {cnt_q, index_q};
        RESP:  rsp_valid_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
